// File: rtl/bp_resolve_ctrl.sv
// Branch-resolution controller: in-order prediction tracking queue, misprediction
// detection, flush/redirect/drain sequencing and predictor training updates.
module bp_resolve_ctrl #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned DRAIN_CYC = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       pred_valid_i,
    input  logic                       pred_taken_i,
    input  logic [31:0]                pred_target_i,
    input  logic [31:0]                pred_fallthru_i,
    output logic                       pred_ready_o,
    input  logic                       res_valid_i,
    input  logic                       res_taken_i,
    input  logic [31:0]                res_target_i,
    output logic                       flush_o,
    output logic [31:0]                redirect_pc_o,
    output logic                       fetch_hold_o,
    output logic                       upd_valid_o,
    output logic                       upd_taken_o,
    output logic                       upd_mispred_o,
    output logic [$clog2(DEPTH):0]     occupancy_o,
    output logic [31:0]                mispred_cnt_o,
    output logic                       res_err_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, FLUSH, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [AW-1:0] wr_idx, rd_idx;
    logic [3:0]    drain_cnt;

    logic          q_taken    [DEPTH];
    logic [31:0]   q_target   [DEPTH];
    logic [31:0]   q_fallthru [DEPTH];

    logic          full, empty, push, res_acc, mispred;
    logic [31:0]   actual_pc, pred_pc;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    assign empty  = (wr_ptr == rd_ptr);

    assign pred_ready_o = !full && (state == IDLE);
    assign push         = pred_valid_i && pred_ready_o;
    assign res_acc      = res_valid_i && (state == IDLE) && !empty;

    assign actual_pc = res_taken_i ? res_target_i : q_fallthru[rd_idx];
    assign pred_pc   = q_taken[rd_idx] ? q_target[rd_idx] : q_fallthru[rd_idx];
    assign mispred   = res_acc && (actual_pc != pred_pc);

    assign occupancy_o = wr_ptr - rd_ptr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mispred) state_nxt = FLUSH;
            FLUSH:   state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        flush_o      = (state == FLUSH);
        fetch_hold_o = (state != IDLE);
    end

    // Counter is loaded during FLUSH so DRAIN lasts exactly DRAIN_CYC cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drain_cnt <= '0;
        end else if (state == FLUSH) begin
            drain_cnt <= 4'(DRAIN_CYC - 1);
        end else if (state == DRAIN && drain_cnt != '0) begin
            drain_cnt <= drain_cnt - 4'd1;
        end
    end

    // A mispredict empties the queue, discarding any same-cycle push.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (mispred) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)    wr_ptr <= wr_ptr + (AW+1)'(1);
            if (res_acc) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            q_taken[wr_idx]    <= pred_taken_i;
            q_target[wr_idx]   <= pred_target_i;
            q_fallthru[wr_idx] <= pred_fallthru_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            upd_valid_o   <= 1'b0;
            upd_taken_o   <= 1'b0;
            upd_mispred_o <= 1'b0;
            redirect_pc_o <= '0;
            mispred_cnt_o <= '0;
            res_err_o     <= 1'b0;
        end else begin
            upd_valid_o   <= res_acc;
            upd_taken_o   <= res_acc && res_taken_i;
            upd_mispred_o <= mispred;
            if (mispred) begin
                redirect_pc_o <= actual_pc;
                mispred_cnt_o <= mispred_cnt_o + 32'd1;
            end
            if (res_valid_i && (state == IDLE) && empty) begin
                res_err_o <= 1'b1;
            end
        end
    end

endmodule
